des_key_sched_seq: RTL
======================

Name: des_key_sched_seq

Overview:
- Sequential DES key scheduler. It accepts one 64-bit key per load and streams the 16 round keys one per handshake.
- Encrypt order is K1..K16 using left rotations. Decrypt order is K16..K1 using right rotations, so no 16-entry key table is stored.
- Sits between the key-load interface and an iterative (one round per cycle) DES datapath.

Parameters:
- NUM_ROUNDS, 16, round keys emitted per load; fixed by DES; the shift schedule is sized to it.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- key_in  input  64  key; key_in[i] = FIPS 46-3 key bit i+1; PC-1 uses the same numbering.
- decrypt  input  1  sampled with key_in; 1 = emit K16..K1.
- key_valid  input  1  load request.
- key_ready  output  1  high only in IDLE.
- rk_out  output  48  current round key; rk_out[j] = FIPS PC-2 output bit j+1.
- rk_idx  output  4  FIPS round number minus 1 of rk_out (0..15).
- rk_last  output  1  high with the 16th key of a load.
- rk_valid  output  1  rk_out valid.
- rk_ready  input  1  consumer accepts rk_out.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; C,D registers=0; count=0; mode=0.
  - rk_valid=0, rk_out=0, rk_idx=0, rk_last=0, key_ready=1.
- States: IDLE, RUN.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid&key_ready: capture PC-1(key_in) into C (28b) and D (28b), capture mode=decrypt, count=0, go to RUN.
  - Encrypt: the registered C,D are rotated left by 1 at capture, giving C1D1.
  - Decrypt: captured unrotated (C16D16 = C0D0).
- RUN:
  - rk_valid=1; rk_out = PC-2(C,D) combinationally from registers.
  - rk_idx = count (encrypt) or 15-count (decrypt).
  - rk_last = (count==15).
  - First key therefore appears the cycle after the load handshake (latency 1).
- On rk_valid&rk_ready in RUN with count<15: count++ and rotate C and D.
  - Encrypt: rotate left by SHIFT[count+1].
  - Decrypt: rotate right by SHIFT[15-count].
  - SHIFT[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Rotation is within each 28-bit half; wrap is modular 28.
- On rk_valid&rk_ready with count==15: go to IDLE, rk_valid=0 next cycle.
  - Total rotation is 28 per half, so C,D return to C0D0 (an assertion checks this).
- Backpressure:
  - rk_ready low holds rk_out, rk_idx and rk_last stable while rk_valid=1.
  - No key is skipped or repeated.
- Loads during RUN: key_ready=0, so key_valid is ignored. No same-cycle IDLE re-load after the last handshake; the next load is accepted one cycle later in IDLE.
- Throughput: 16 keys in 16 cycles with rk_ready held high. Back-to-back loads cost one IDLE cycle.
- Reset mid-stream: immediate return to reset values; partial stream abandoned, no completion signalled.
- Parity bits key_in[8k+7] are dropped by PC-1 and do not affect round keys.

Optional Feature:
- Macro DES_KEYSCHED_PARITY_CHK_EN.
- Defined:
  - Adds output port parity_err (1b, reset 0).
  - At the load handshake, each byte key_in[8k+7:8k] is checked for odd parity.
  - On any failure the handshake still completes, but no round keys are emitted (state stays IDLE) and parity_err pulses high for exactly one cycle.
  - On success, behaviour is as above and parity_err stays 0.
- Undefined: port absent, parity never checked.

Test Plan:
- Encrypt: key_in = bitrev64(64'h133457799BBCDFF1), decrypt=0, rk_ready=1 -> cycle after load rk_out = bitrev48(48'h1B02EFFC7072), rk_idx=0; 16th key = bitrev48(48'hCB3D8B0E17F5), rk_idx=15, rk_last=1; then key_ready=1.
- Decrypt: same key, decrypt=1 -> first rk_out = bitrev48(48'hCB3D8B0E17F5) with rk_idx=15; last = bitrev48(48'h1B02EFFC7072) with rk_idx=0, rk_last=1; sequence equals the encrypt sequence reversed.
- Backpressure: random rk_ready (≈50%) over 4 random keys, both modes -> every key matches the reference model, values stable while stalled, exactly 16 accepted per load.
- Load while busy: key_valid asserted with a second key during RUN -> ignored; second key accepted only after rk_last handshake plus one IDLE cycle.
- Reset: rst_n low after the 5th key -> rk_valid=0 and key_ready=1 asynchronously; next load produces a full correct 16-key stream.
- DES_KEYSCHED_PARITY_CHK_EN: key 64'h0 (all bytes even parity) -> parity_err=1 for 1 cycle, rk_valid stays 0. key bitrev64(64'h133457799BBCDFF1) (valid odd parity) -> parity_err=0, normal stream.

Source files
------------

// File: rtl/des_key_sched_seq.sv
// Sequential DES key scheduler: one 48-bit round key per rk handshake.
// Define DES_KEYSCHED_PARITY_CHK_EN to add the odd-parity key check.
module des_key_sched_seq #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] rk_out,
    output logic [3:0]  rk_idx,
    output logic        rk_last,
    output logic        rk_valid,
    input  logic        rk_ready
`ifdef DES_KEYSCHED_PARITY_CHK_EN
    ,
    output logic        parity_err
`endif
);

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

    // Rounds that shift by one position: 1, 2, 9 and 16.
    localparam logic [15:0] ONE_SHIFT = 16'h8103;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [27:0] c, c_nxt;
    logic [27:0] d, d_nxt;
    logic [3:0]  count, count_nxt;
    logic        mode, mode_nxt;
    logic [55:0] cd0;
    logic        key_fire;
    logic        par_ok;
    logic        load_go;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int j = 0; j < 56; j++) r[j] = k[PC1[j] - 1];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) r[j] = cd[PC2[j] - 1];
        return r;
    endfunction

    // Bit 0 holds the first FIPS bit, so a FIPS left rotate moves bits down.
    function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    assign cd0       = pc1(key_in);
    assign key_ready = (state == IDLE);
    assign key_fire  = key_valid & key_ready;
    assign load_go   = key_fire & par_ok;

`ifdef DES_KEYSCHED_PARITY_CHK_EN
    always_comb begin
        par_ok = 1'b1;
        for (int b = 0; b < 8; b++) par_ok &= ^key_in[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err <= 1'b0;
        else        parity_err <= key_fire & ~par_ok;
    end
`else
    logic unused_par_bits;

    assign par_ok = 1'b1;
    assign unused_par_bits = ^{key_in[63], key_in[55], key_in[47], key_in[39],
                               key_in[31], key_in[23], key_in[15], key_in[7]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            c     <= '0;
            d     <= '0;
            count <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_nxt;
            c     <= c_nxt;
            d     <= d_nxt;
            count <= count_nxt;
            mode  <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        c_nxt     = c;
        d_nxt     = d;
        count_nxt = count;
        mode_nxt  = mode;
        unique case (state)
            IDLE: begin
                if (load_go) begin
                    state_nxt = RUN;
                    mode_nxt  = decrypt;
                    count_nxt = '0;
                    // Encrypt starts at C1D1; decrypt starts at C16D16 = C0D0.
                    c_nxt = decrypt ? cd0[27:0]  : rotl(cd0[27:0], 1'b0);
                    d_nxt = decrypt ? cd0[55:28] : rotl(cd0[55:28], 1'b0);
                end
            end
            RUN: begin
                if (rk_ready) begin
                    if (count == LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        count_nxt = count + 4'd1;
                        if (mode) begin
                            c_nxt = rotr(c, ~ONE_SHIFT[LAST - count]);
                            d_nxt = rotr(d, ~ONE_SHIFT[LAST - count]);
                        end else begin
                            c_nxt = rotl(c, ~ONE_SHIFT[count + 4'd1]);
                            d_nxt = rotl(d, ~ONE_SHIFT[count + 4'd1]);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign rk_valid = (state == RUN);
    assign rk_out   = rk_valid ? pc2({d, c}) : '0;
    assign rk_idx   = rk_valid ? (mode ? LAST - count : count) : '0;
    assign rk_last  = rk_valid & (count == LAST);

`ifndef SYNTHESIS
    logic [55:0] cd_ref;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cd_ref <= '0;
        else if (load_go) cd_ref <= cd0;
    end

    // A full stream rotates each half by 28, landing back on C0D0.
    a_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        (rk_valid && rk_ready && rk_last) |->
        ((mode ? {rotr(d, 1'b0), rotr(c, 1'b0)} : {d, c}) == cd_ref));
`endif

endmodule
